// File: rtl/timer_ctrl_pkg.sv
// Shared types and constants for the timing-counter sequencer and its watchdog.
package timer_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int unsigned WDOG_MARGIN = 8;

  // A healthy Counter flags within 2^WIDTH cycles; the margin absorbs restart latency.
  function automatic int unsigned wdog_limit(input int unsigned width);
    return (32'd1 << width) + WDOG_MARGIN;
  endfunction

endpackage

// File: rtl/timer_ctrl_if.sv
// Bundle between the game FSM / Counter (master side) and timer_ctrl (slave side).
interface timer_ctrl_if #(
  parameter int PW = 4
);
  logic          i_Start;
  logic [PW-1:0] i_Periods;
  logic          i_Abort;
  logic          i_TwoSec;
  logic          o_RstCounter;
  logic          o_ActCounter;
  logic          o_Busy;
  logic          o_Done;
  logic [PW-1:0] o_Remaining;
  logic          o_Error;

  modport master (
    output i_Start, i_Periods, i_Abort, i_TwoSec,
    input  o_RstCounter, o_ActCounter, o_Busy, o_Done, o_Remaining, o_Error
  );

  modport slave (
    input  i_Start, i_Periods, i_Abort, i_TwoSec,
    output o_RstCounter, o_ActCounter, o_Busy, o_Done, o_Remaining, o_Error
  );
endinterface

// File: rtl/timer_wdog.sv
// Watchdog cycle counter: counts RUN cycles since the last restart and flags
// expiry when 2^WIDTH+WDOG_MARGIN cycles pass without a two-second flag.
module timer_wdog
  import timer_ctrl_pkg::*;
#(
  parameter int WIDTH = 12
) (
  input  logic clk_2K,
  input  logic i_Reset,
  input  logic run_i,
  input  logic restart_i,
  output logic expired_o
);

  localparam int unsigned LIMIT = wdog_limit(WIDTH);
  localparam int          CW    = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // expired_o is high during the cycle that completes the LIMIT-th RUN cycle.
  assign expired_o = run_i && !restart_i && (cnt_q == CW'(LIMIT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (restart_i || !run_i) begin
      cnt_d = '0;
    end else if (!expired_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_2K) begin
    if (i_Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// Sequencer between the game FSM and the two-second Counter: waits N periods.
// Optional watchdog enabled by defining TIMER_CTRL_WATCHDOG_EN.
module timer_ctrl
  import timer_ctrl_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int PW    = 4
) (
  input  logic         clk_2K,
  input  logic         i_Reset,
  timer_ctrl_if.slave  bus
);

  state_e        state_q, state_d;
  logic [PW-1:0] rem_q, rem_d;
  logic          err_q, err_d;
  logic          rst_ctr_q, act_ctr_q, busy_q, done_q;
  logic          wdog_exp;

`ifdef TIMER_CTRL_WATCHDOG_EN
  timer_wdog #(
    .WIDTH (WIDTH)
  ) u_wdog (
    .clk_2K    (clk_2K),
    .i_Reset   (i_Reset),
    .run_i     (state_q == RUN),
    .restart_i (state_q == CLEAR),
    .expired_o (wdog_exp)
  );
`else
  assign wdog_exp = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.i_Start && !bus.i_Abort) begin
          if (bus.i_Periods == '0) begin
            state_d = DONE;
          end else begin
            state_d = CLEAR;
            rem_d   = bus.i_Periods;
            err_d   = 1'b0;
          end
        end
      end
      CLEAR: begin
        if (bus.i_Abort) begin
          state_d = IDLE;
          rem_d   = '0;
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        // Abort outranks a coincident flag; a flag outranks watchdog expiry.
        if (bus.i_Abort) begin
          state_d = IDLE;
          rem_d   = '0;
        end else if (bus.i_TwoSec) begin
          if (rem_q <= PW'(1)) begin
            rem_d   = '0;
            state_d = DONE;
          end else begin
            rem_d   = rem_q - 1'b1;
            state_d = CLEAR;
          end
        end else if (wdog_exp) begin
          err_d   = 1'b1;
          rem_d   = '0;
          state_d = IDLE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they are registered with it.
  always_ff @(posedge clk_2K) begin
    if (i_Reset) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      err_q     <= 1'b0;
      rst_ctr_q <= 1'b0;
      act_ctr_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      err_q     <= err_d;
      rst_ctr_q <= (state_d == CLEAR);
      act_ctr_q <= (state_d == RUN);
      busy_q    <= (state_d == CLEAR) || (state_d == RUN);
      done_q    <= (state_d == DONE);
    end
  end

  assign bus.o_RstCounter = rst_ctr_q;
  assign bus.o_ActCounter = act_ctr_q;
  assign bus.o_Busy       = busy_q;
  assign bus.o_Done       = done_q;
  assign bus.o_Remaining  = rem_q;
  assign bus.o_Error      = err_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl: a period-level behavioural model checked every
// cycle, plus hand-computed literal expectations for each scenario.
module tb_timer_ctrl;

  localparam int WIDTH = 12;
  localparam int PW    = 4;
  localparam int WDOG  = (1 << WIDTH) + 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  timer_ctrl_if #(.PW(PW)) tif ();

  timer_ctrl #(
    .WIDTH (WIDTH),
    .PW    (PW)
  ) dut (
    .clk_2K  (clk),
    .i_Reset (rst),
    .bus     (tif)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Model: a wait is "busy"; its first cycle of each period is the clear cycle.
  bit m_busy, m_clear, m_done, m_err;
  int m_rem, m_wd;

  int rst_pulses, done_pulses, busy_cycles;

  task automatic chk(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    if (rst) begin
      m_busy = 0; m_clear = 0; m_done = 0; m_err = 0; m_rem = 0; m_wd = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (!m_busy) begin
      if (tif.i_Start && !tif.i_Abort) begin
        if (tif.i_Periods == 0) begin
          m_done = 1;
        end else begin
          m_busy = 1; m_clear = 1; m_rem = int'(tif.i_Periods); m_err = 0;
        end
      end
    end else if (tif.i_Abort) begin
      m_busy = 0; m_clear = 0; m_rem = 0;
    end else if (m_clear) begin
      m_clear = 0; m_wd = 0;
    end else if (tif.i_TwoSec) begin
      if (m_rem == 1) begin
        m_rem = 0; m_busy = 0; m_done = 1;
      end else begin
        m_rem = m_rem - 1; m_clear = 1;
      end
    end else begin
`ifdef TIMER_CTRL_WATCHDOG_EN
      m_wd = m_wd + 1;
      if (m_wd == WDOG) begin
        m_err = 1; m_busy = 0; m_rem = 0;
      end
`endif
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    chk("busy",     int'(tif.o_Busy),       int'(m_busy));
    chk("rst_ctr",  int'(tif.o_RstCounter), int'(m_busy && m_clear));
    chk("act_ctr",  int'(tif.o_ActCounter), int'(m_busy && !m_clear));
    chk("done",     int'(tif.o_Done),       int'(m_done));
    chk("remain",   int'(tif.o_Remaining),  m_rem);
    chk("error",    int'(tif.o_Error),      int'(m_err));
    if (tif.o_RstCounter) rst_pulses++;
    if (tif.o_Done)       done_pulses++;
    if (tif.o_Busy)       busy_cycles++;
  endtask

  task automatic start_req(input int p);
    tif.i_Start   = 1'b1;
    tif.i_Periods = PW'(p);
    step();
    tif.i_Start   = 1'b0;
  endtask

  task automatic clear_counts();
    rst_pulses = 0; done_pulses = 0; busy_cycles = 0;
  endtask

  initial begin
    rst = 1'b1;
    tif.i_Start = 1'b0; tif.i_Periods = '0; tif.i_Abort = 1'b0; tif.i_TwoSec = 1'b0;
    clear_counts();

    // Reset state
    repeat (3) step();
    chk("reset_busy", int'(tif.o_Busy), 0);
    chk("reset_done", int'(tif.o_Done), 0);
    chk("reset_act",  int'(tif.o_ActCounter), 0);
    rst = 1'b0;
    repeat (2) step();

    // Single period
    clear_counts();
    start_req(1);
    chk("p1_rst_n1",  int'(tif.o_RstCounter), 1);
    chk("p1_busy_n1", int'(tif.o_Busy), 1);
    chk("p1_act_n1",  int'(tif.o_ActCounter), 0);
    chk("p1_rem_n1",  int'(tif.o_Remaining), 1);
    step();
    chk("p1_act_n2",  int'(tif.o_ActCounter), 1);
    chk("p1_rst_n2",  int'(tif.o_RstCounter), 0);
    repeat (3) step();
    tif.i_TwoSec = 1'b1; step(); tif.i_TwoSec = 1'b0;
    chk("p1_done",      int'(tif.o_Done), 1);
    chk("p1_busy_done", int'(tif.o_Busy), 0);
    chk("p1_act_done",  int'(tif.o_ActCounter), 0);
    chk("p1_rem_done",  int'(tif.o_Remaining), 0);
    step();
    chk("p1_done_off",  int'(tif.o_Done), 0);
    chk("p1_rst_pulses",  rst_pulses, 1);
    chk("p1_done_pulses", done_pulses, 1);

    // Three periods
    clear_counts();
    start_req(3);
    chk("p3_rem_start", int'(tif.o_Remaining), 3);
    for (int k = 0; k < 3; k++) begin
      repeat (3) step();
      tif.i_TwoSec = 1'b1; step(); tif.i_TwoSec = 1'b0;
      chk("p3_rem_step", int'(tif.o_Remaining), 2 - k);
    end
    repeat (2) step();
    chk("p3_rst_pulses",  rst_pulses, 3);
    chk("p3_done_pulses", done_pulses, 1);

    // Zero periods
    clear_counts();
    start_req(0);
    chk("p0_done", int'(tif.o_Done), 1);
    chk("p0_busy", int'(tif.o_Busy), 0);
    chk("p0_rst",  int'(tif.o_RstCounter), 0);
    repeat (2) step();
    chk("p0_rst_pulses", rst_pulses, 0);
    chk("p0_busy_cycles", busy_cycles, 0);
    chk("p0_done_pulses", done_pulses, 1);

    // Abort coincident with the flag, remaining=2; start while busy ignored
    clear_counts();
    start_req(3);
    repeat (2) step();
    tif.i_TwoSec = 1'b1; step(); tif.i_TwoSec = 1'b0;
    step();
    tif.i_Start = 1'b1; tif.i_Periods = 4'd5; step(); tif.i_Start = 1'b0;
    chk("busy_start_rem", int'(tif.o_Remaining), 2);
    step();
    tif.i_Abort = 1'b1; tif.i_TwoSec = 1'b1; step();
    tif.i_Abort = 1'b0; tif.i_TwoSec = 1'b0;
    chk("abort_busy", int'(tif.o_Busy), 0);
    chk("abort_rem",  int'(tif.o_Remaining), 0);
    chk("abort_done", int'(tif.o_Done), 0);
    chk("abort_act",  int'(tif.o_ActCounter), 0);
    repeat (2) step();
    chk("abort_done_pulses", done_pulses, 0);

    // Flag during the clear cycle and in IDLE is ignored
    start_req(2);
    tif.i_TwoSec = 1'b1; step(); tif.i_TwoSec = 1'b0;
    chk("clear_flag_rem", int'(tif.o_Remaining), 2);
    chk("clear_flag_act", int'(tif.o_ActCounter), 1);
    tif.i_Abort = 1'b1; step(); tif.i_Abort = 1'b0;
    tif.i_TwoSec = 1'b1; repeat (2) step(); tif.i_TwoSec = 1'b0;
    chk("idle_flag_busy", int'(tif.o_Busy), 0);
    chk("idle_flag_done", int'(tif.o_Done), 0);

    // Abort in IDLE masks a start
    tif.i_Abort = 1'b1; tif.i_Start = 1'b1; tif.i_Periods = 4'd2; step();
    tif.i_Abort = 1'b0; tif.i_Start = 1'b0;
    chk("idle_abort_busy", int'(tif.o_Busy), 0);
    step();

    // Reset held 3 cycles mid-RUN, then a normal single period
    start_req(2);
    repeat (2) step();
    rst = 1'b1; step();
    chk("midrst_busy", int'(tif.o_Busy), 0);
    chk("midrst_act",  int'(tif.o_ActCounter), 0);
    chk("midrst_rst",  int'(tif.o_RstCounter), 0);
    chk("midrst_rem",  int'(tif.o_Remaining), 0);
    repeat (2) step();
    rst = 1'b0; step();
    clear_counts();
    start_req(1);
    chk("postrst_rst", int'(tif.o_RstCounter), 1);
    repeat (3) step();
    tif.i_TwoSec = 1'b1; step(); tif.i_TwoSec = 1'b0;
    chk("postrst_done", int'(tif.o_Done), 1);
    step();
    chk("postrst_done_pulses", done_pulses, 1);

`ifdef TIMER_CTRL_WATCHDOG_EN
    // Watchdog: no flag ever arrives
    clear_counts();
    start_req(1);
    step();
    repeat (WDOG - 1) step();
    chk("wdog_err_early", int'(tif.o_Error), 0);
    step();
    chk("wdog_err",  int'(tif.o_Error), 1);
    chk("wdog_busy", int'(tif.o_Busy), 0);
    repeat (3) step();
    chk("wdog_done_pulses", done_pulses, 0);
    chk("wdog_err_sticky", int'(tif.o_Error), 1);
    start_req(2);
    chk("wdog_err_clear", int'(tif.o_Error), 0);
    tif.i_Abort = 1'b1; step(); tif.i_Abort = 1'b0;
    step();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
